// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types, default widths and round-robin helper for reg_bank_arbiter
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ    = 2;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_TIMEOUT    = 15;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 < n) ? idx + 1 : 0;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// rtl/reg_bank_arbiter_rr_pick.sv - combinational round-robin select: first set request at or after ptr, wrapping
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   int unsigned cand;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = 0;
      for (int k = 0; k < N; k++) begin
         cand = 32'(ptr) + 32'(k);
         if (cand >= 32'(N)) cand = cand - 32'(N);
         if (!any && req[cand]) begin
            any          = 1'b1;
            onehot[cand] = 1'b1;
            idx          = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbiter sharing one register-bank port among NUM_REQ requesters
// Defining REG_ARB_TIMEOUT_EN adds an ISSUE-state timeout reported through rsp_err.
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_sel,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_gnt,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          m_sel,
   output logic                          m_wr,
   output logic [ADDR_WIDTH-1:0]         m_addr,
   output logic [DATA_WIDTH-1:0]         m_wdata,
   input  logic                          m_ready,
   input  logic [DATA_WIDTH-1:0]         m_rdata
);
   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t             state, state_d;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_d;
   logic [NUM_REQ-1:0]     win, win_d, gnt_d, vld_d;
   logic [DATA_WIDTH-1:0]  rdata_d, wdata_d;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic                   err_d, sel_d, wr_d;
   logic [NUM_REQ-1:0]     pick_oh;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;

`ifdef REG_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
      .req    (req_sel),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d  = state;
      rr_ptr_d = rr_ptr;
      win_d    = win;
      gnt_d    = '0;
      vld_d    = '0;
      rdata_d  = rsp_rdata;
      err_d    = 1'b0;
      sel_d    = m_sel;
      wr_d     = m_wr;
      addr_d   = m_addr;
      wdata_d  = m_wdata;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_d    = cnt;
`endif
      case (state)
         IDLE: begin
            // The requester being answered still shows req_sel this cycle, so hold off arbitration.
            if (pick_any && rsp_valid == '0) begin
               state_d  = ISSUE;
               win_d    = pick_oh;
               gnt_d    = pick_oh;
               sel_d    = 1'b1;
               wr_d     = req_wr[pick_idx];
               addr_d   = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d  = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               rr_ptr_d = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
`ifdef REG_ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         ISSUE: begin
            if (m_ready) begin
               sel_d = 1'b0;
               if (m_wr) begin
                  vld_d   = win;
                  state_d = IDLE;
               end else begin
                  state_d = RDATA;
               end
            end
`ifdef REG_ARB_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               sel_d   = 1'b0;
               vld_d   = win;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
`endif
         end
         RDATA: begin
            rdata_d = m_rdata;
            vld_d   = win;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         win       <= '0;
         req_gnt   <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         m_sel     <= 1'b0;
         m_wr      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
`ifdef REG_ARB_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= state_d;
         rr_ptr    <= rr_ptr_d;
         win       <= win_d;
         req_gnt   <= gnt_d;
         rsp_valid <= vld_d;
         rsp_rdata <= rdata_d;
         rsp_err   <= err_d;
         m_sel     <= sel_d;
         m_wr      <= wr_d;
         m_addr    <= addr_d;
         m_wdata   <= wdata_d;
`ifdef REG_ARB_TIMEOUT_EN
         cnt       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed and randomized self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;
   localparam int N   = 2;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int TMO = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_sel, req_wr, req_gnt, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, m_wdata, m_rdata;
   logic            rsp_err, m_sel, m_wr, m_ready;
   logic [AW-1:0]   m_addr;

   logic [DW-1:0]   bank_mem [256];
   logic [DW-1:0]   ref_mem  [256];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_bank_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_sel   (req_sel),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_gnt   (req_gnt),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m_sel     (m_sel),
      .m_wr      (m_wr),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_ready   (m_ready),
      .m_rdata   (m_rdata)
   );

   // Bank: writes land on accept, read data registered one cycle after accept.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) bank_mem[k] <= '0;
         m_rdata <= '0;
      end else if (m_sel && m_ready) begin
         if (m_wr) bank_mem[m_addr] <= m_wdata;
         else      m_rdata <= bank_mem[m_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_wr[i]            = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // Random-phase requester state and reference model.
   logic          pend   [N];
   logic          c_wr   [N];
   logic [AW-1:0] c_addr [N];
   logic [DW-1:0] c_data [N];
   logic [N-1:0]  drv_req, exp_gnt, exp_vld;
   logic          drv_rdy, cw, gap;
   logic [AW-1:0] ca;
   logic [DW-1:0] cd, exp_rdata;
   int            ph, ptr, cur, w, n, seen, ngnt;
   logic [N-1:0]  gnts [8];
   int            gcyc [8];

   initial begin
      rst = 1'b1; req_sel = '0; req_wr = '0; req_addr = '0; req_wdata = '0; m_ready = 1'b1;
      step; step;
      check("rst_gnt", req_gnt, 0);
      check("rst_vld", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_msel", m_sel, 0);
      check("rst_mwr", m_wr, 0);
      check("rst_maddr", m_addr, 0);
      check("rst_mwdata", m_wdata, 0);
      rst = 1'b0;

      // single write
      set_cmd(0, 1'b1, 8'h10, 16'hBEEF); req_sel = 2'b01;
      step;
      check("wr_gnt", req_gnt, 2'b01);
      check("wr_msel", m_sel, 1);
      check("wr_maddr", m_addr, 8'h10);
      check("wr_mwdata", m_wdata, 16'hBEEF);
      check("wr_mwr", m_wr, 1);
      check("wr_vld_early", rsp_valid, 0);
      step;
      check("wr_vld", rsp_valid, 2'b01);
      check("wr_err", rsp_err, 0);
      check("wr_msel_drop", m_sel, 0);
      req_sel = '0;
      step;
      check("wr_vld_pulse", rsp_valid, 0);

      // put 1234 at 0x20 through requester 1, then read it back via requester 0
      set_cmd(1, 1'b1, 8'h20, 16'h1234); req_sel = 2'b10;
      step; check("wr2_gnt", req_gnt, 2'b10);
      step; check("wr2_vld", rsp_valid, 2'b10);
      req_sel = '0; step;
      set_cmd(0, 1'b0, 8'h20, 16'h0); req_sel = 2'b01;
      step;
      check("rd_gnt", req_gnt, 2'b01);
      check("rd_mwr", m_wr, 0);
      step;
      check("rd_vld_c2", rsp_valid, 0);
      step;
      check("rd_vld_c3", rsp_valid, 2'b01);
      check("rd_rdata", rsp_rdata, 16'h1234);
      req_sel = '0; step;

      // fairness: both requesting continuously, writes
      rst = 1'b1; step; rst = 1'b0;
      set_cmd(0, 1'b1, 8'h01, 16'hAAAA); set_cmd(1, 1'b1, 8'h02, 16'h5555); req_sel = 2'b11;
      ngnt = 0;
      for (int c = 0; c < 60 && ngnt < 8; c++) begin
         step;
         if (req_gnt != '0) begin
            gnts[ngnt] = req_gnt; gcyc[ngnt] = c; ngnt++;
         end
      end
      check("fair_count", ngnt, 8);
      for (int k = 0; k < ngnt; k++) begin
         check("fair_gnt", gnts[k], (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) check("fair_period", gcyc[k] - gcyc[k-1], 3);
      end
      req_sel = '0; step; step; step;

      // stall: read held while m_ready low
      set_cmd(1, 1'b0, 8'h02, 16'h0); req_sel = 2'b10; m_ready = 1'b0;
      step;
      check("stall_gnt", req_gnt, 2'b10);
      for (int k = 0; k < 5; k++) begin
         step;
         check("stall_msel", m_sel, 1);
         check("stall_maddr", m_addr, 8'h02);
         check("stall_vld", rsp_valid, 0);
      end
      m_ready = 1'b1;
      step; check("stall_acc_vld", rsp_valid, 0);
      step;
      check("stall_vld_done", rsp_valid, 2'b10);
      check("stall_rdata", rsp_rdata, 16'h5555);
      req_sel = '0; step;

      // reset while in ISSUE
      set_cmd(1, 1'b1, 8'h30, 16'h7777); req_sel = 2'b10; m_ready = 1'b0;
      step; check("rsti_gnt", req_gnt, 2'b10);
      step;
      rst = 1'b1; step;
      check("rsti_msel", m_sel, 0);
      check("rsti_vld", rsp_valid, 0);
      rst = 1'b0; m_ready = 1'b1;
      set_cmd(0, 1'b1, 8'h31, 16'h1111); req_sel = 2'b11;
      step;
      check("rsti_gnt0", req_gnt, 2'b01);
      check("rsti_novld", rsp_valid, 0);
      req_sel = 2'b10;
      step; check("drop_vld", rsp_valid, 2'b01);
      step; check("gap_gnt", req_gnt, 0);
      step; check("after_gap_gnt", req_gnt, 2'b10);
      step; check("after_gap_vld", rsp_valid, 2'b10);
      req_sel = '0; step;

      // read with m_ready held low
      set_cmd(0, 1'b0, 8'h31, 16'h0); req_sel = 2'b01; m_ready = 1'b0;
      step; check("hold_gnt", req_gnt, 2'b01);
`ifdef REG_ARB_TIMEOUT_EN
      n = 0;
      do begin step; n++; end while (rsp_valid == '0 && n < 40);
      check("tmo_cycles", n, TMO);
      check("tmo_vld", rsp_valid, 2'b01);
      check("tmo_err", rsp_err, 1);
      check("tmo_msel", m_sel, 0);
      check("tmo_rdata", rsp_rdata, 16'h0);
      req_sel = '0; m_ready = 1'b1;
      step; check("tmo_idle_msel", m_sel, 0);
`else
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         step;
         if (rsp_valid != '0) seen++;
      end
      check("hold_norsp", seen, 0);
      check("hold_msel", m_sel, 1);
      m_ready = 1'b1;
      step; check("hold_acc_vld", rsp_valid, 0);
      step;
      check("hold_vld", rsp_valid, 2'b01);
      check("hold_err", rsp_err, 0);
      check("hold_rdata", rsp_rdata, 16'h1111);
      req_sel = '0; step;
`endif

      // randomized traffic against a transaction-level model
      rst = 1'b1; req_sel = '0; step; rst = 1'b0;
      for (int k = 0; k < 256; k++) ref_mem[k] = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      ph = 0; ptr = 0; cur = 0; gap = 1'b0; exp_rdata = '0;
      cw = 1'b0; ca = '0; cd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drv_req = req_sel; drv_rdy = m_ready;
         step;
         exp_gnt = '0; exp_vld = '0;
         if (ph == 0) begin
            if (!gap && drv_req != '0) begin
               w = -1;
               for (int k = 0; k < N; k++)
                  if (w < 0 && drv_req[(ptr + k) % N]) w = (ptr + k) % N;
               exp_gnt[w] = 1'b1;
               ptr = (w + 1) % N;
               cur = w; cw = c_wr[w]; ca = c_addr[w]; cd = c_data[w];
               ph = 1;
            end
         end else if (ph == 1) begin
            if (drv_rdy) begin
               if (cw) begin
                  ref_mem[ca] = cd; exp_vld[cur] = 1'b1; ph = 0;
               end else begin
                  ph = 2;
               end
            end
         end else begin
            exp_rdata = ref_mem[ca]; exp_vld[cur] = 1'b1; ph = 0;
         end
         gap = (exp_vld != '0);
         check("rnd_gnt", req_gnt, exp_gnt);
         check("rnd_vld", rsp_valid, exp_vld);
         check("rnd_err", rsp_err, 0);
         check("rnd_msel", m_sel, (ph == 1) ? 1 : 0);
         check("rnd_rdata", rsp_rdata, exp_rdata);
         if (ph == 1) begin
            check("rnd_maddr", m_addr, ca);
            check("rnd_mwr", m_wr, cw);
            check("rnd_mwdata", m_wdata, cd);
         end
         for (int i = 0; i < N; i++) begin
            if (exp_gnt[i] && $urandom_range(3) == 0) begin
               req_sel[i] = 1'b0;
               c_addr[i] = AW'($urandom); c_data[i] = DW'($urandom); c_wr[i] = $urandom_range(1) == 1;
            end
            if (pend[i] && exp_vld[i]) begin
               pend[i] = 1'b0; req_sel[i] = 1'b0;
            end
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1; req_sel[i] = 1'b1;
               c_wr[i] = $urandom_range(1) == 1;
               c_addr[i] = AW'($urandom_range(15));
               c_data[i] = DW'($urandom);
            end
            set_cmd(i, c_wr[i], c_addr[i], c_data[i]);
         end
         m_ready = ($urandom_range(3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
